// File: rtl/sparse_cfg_pkg.sv
// Shared types and address-field constants for the sparse config responder.
package sparse_cfg_pkg;

    typedef enum logic [1:0] {
        ST_UNCFG  = 2'd0,
        ST_CFGING = 2'd1,
        ST_READY  = 2'd2
    } cfg_state_t;

    localparam int unsigned TILE_LSB   = 0;
    localparam int unsigned TILE_MSB   = 15;
    localparam int unsigned IDX_LSB    = 24;
    localparam int unsigned IDX_MSB    = 31;
    localparam int unsigned COMMIT_BIT = 0;

endpackage

// File: rtl/sparse_cfg_regfile.sv
// NUM_REGS x 32 register storage: one write port, one registered read port
// (out-of-range reads return zero) and a flattened view of all registers.
module sparse_cfg_regfile
    import sparse_cfg_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_we,
    input  logic [AW-1:0]          i_waddr,
    input  logic [31:0]            i_wdata,
    input  logic                   i_re,
    input  logic                   i_rzero,
    input  logic [AW-1:0]          i_raddr,
    output logic [31:0]            o_rdata,
    output logic [NUM_REGS*32-1:0] o_flat
);

    logic [31:0] r_mem [NUM_REGS];
    logic [31:0] r_rdata;

    // Register array write port; cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; samples the pre-write value on a same-edge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rzero ? '0 : r_mem[i_raddr];
        end
    end

    // Flatten the array so register i lands at bits [32*i+31:32*i].
    always_comb begin
        o_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            o_flat[32*i +: 32] = r_mem[i];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sparse_cfg_responder.sv
// Tile-addressed config responder: address decode, configuration FSM,
// sticky error flag and saturating write counter around a register file.
module sparse_cfg_responder
    import sparse_cfg_pkg::*;
#(
    parameter logic [15:0] TILE_ID  = 16'h0000,
    parameter int          NUM_REGS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [31:0]            config_config_addr,
    input  logic [31:0]            config_config_data,
    input  logic                   config_read,
    input  logic                   config_write,
    output logic [31:0]            read_config_data,
    output logic                   read_valid,
    output logic [NUM_REGS*32-1:0] cfg_regs,
    output logic                   config_done,
    output logic                   cfg_err,
    output logic [15:0]            write_count
);

    localparam int          AW         = $clog2(NUM_REGS);
    localparam logic [8:0]  NREGS9     = 9'(NUM_REGS);
    localparam logic [7:0]  COMMIT_IDX = 8'(NUM_REGS - 1);

    cfg_state_t  r_state, w_state_nxt;
    logic        r_rvalid;
    logic        r_err;
    logic [15:0] r_wcount;

    logic [7:0]  w_idx;
    logic        w_tile;
    logic        w_idx_ok;
    logic        w_hit;
    logic        w_wr_acc;
    logic        w_rd_do;
    logic        w_err;
    logic        w_commit;

    assign w_idx    = config_config_addr[IDX_MSB:IDX_LSB];
    assign w_tile   = (config_config_addr[TILE_MSB:TILE_LSB] == TILE_ID);
    assign w_idx_ok = ({1'b0, w_idx} < NREGS9);
    assign w_hit    = w_tile & w_idx_ok;
    assign w_wr_acc = config_write & w_hit & stall;
    // A write to this tile always wins over a simultaneous read.
    assign w_rd_do  = config_read & w_tile & ~config_write;
    assign w_err    = w_tile & ((~w_idx_ok & (config_read | config_write))
                              | (config_write & w_idx_ok & ~stall)
                              | (config_read & config_write));
    assign w_commit = w_wr_acc & (w_idx == COMMIT_IDX)
                    & config_config_data[COMMIT_BIT];

    sparse_cfg_regfile #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_regfile (
        .clk      (clk),
        .rst      (reset),
        .i_we     (w_wr_acc),
        .i_waddr  (w_idx[AW-1:0]),
        .i_wdata  (config_config_data),
        .i_re     (w_rd_do),
        .i_rzero  (~w_idx_ok),
        .i_raddr  (w_idx[AW-1:0]),
        .o_rdata  (read_config_data),
        .o_flat   (cfg_regs)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_UNCFG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: any accepted write lands in READY if it commits, else CFGING.
    always_comb begin
        w_state_nxt = r_state;
        if (w_wr_acc) begin
            w_state_nxt = w_commit ? ST_READY : ST_CFGING;
        end
    end

    // Read-valid pulse, sticky error flag and saturating accepted-write count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_wcount <= '0;
        end else begin
            r_rvalid <= w_rd_do;
            if (w_err) begin
                r_err <= 1'b1;
            end
            if (w_wr_acc && (r_wcount != 16'hFFFF)) begin
                r_wcount <= r_wcount + 16'd1;
            end
        end
    end

    assign read_valid  = r_rvalid;
    assign cfg_err     = r_err;
    assign write_count = r_wcount;
    assign config_done = (r_state == ST_READY);

endmodule

// File: tb/tb_sparse_cfg_responder.sv
// Directed self-checking bench for sparse_cfg_responder (TILE_ID=0, NUM_REGS=16).
module tb_sparse_cfg_responder;

    logic         clk;
    logic         reset;
    logic         stall;
    logic [31:0]  config_config_addr;
    logic [31:0]  config_config_data;
    logic         config_read;
    logic         config_write;
    logic [31:0]  read_config_data;
    logic         read_valid;
    logic [511:0] cfg_regs;
    logic         config_done;
    logic         cfg_err;
    logic [15:0]  write_count;

    int checks = 0;
    int errors = 0;

    sparse_cfg_responder #(
        .TILE_ID  (16'h0000),
        .NUM_REGS (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .stall              (stall),
        .config_config_addr (config_config_addr),
        .config_config_data (config_config_data),
        .config_read        (config_read),
        .config_write       (config_write),
        .read_config_data   (read_config_data),
        .read_valid         (read_valid),
        .cfg_regs           (cfg_regs),
        .config_done        (config_done),
        .cfg_err            (cfg_err),
        .write_count        (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        config_read = 1'b0;
        config_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one request for one cycle; returns at the following negedge.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        config_read = rd;
        config_write = wr;
        config_config_addr = a;
        config_config_data = d;
        @(negedge clk);
        config_read = 1'b0;
        config_write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cfg_regs !== '0 || read_config_data !== 32'h0 || read_valid !== 1'b0 ||
            write_count !== 16'h0 || cfg_err !== 1'b0 || config_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: regs_nz=%0d rdata=%h rv=%b wc=%h err=%b done=%b (all required 0)",
                     cfg_regs != '0, read_config_data, read_valid, write_count, cfg_err, config_done);
        end
    endtask

    task automatic test_write_read();
        stall = 1'b1;
        req(1'b0, 1'b1, 32'h0300_0000, 32'hDEAD_BEEF);
        checks++;
        if (cfg_regs[127:96] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_reg3: got %h required DEADBEEF", cfg_regs[127:96]);
        end
        checks++;
        if (write_count !== 16'd1 || config_done !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL write_status: wc=%h done=%b err=%b required 1/0/0", write_count, config_done, cfg_err);
        end
        stall = 1'b0;
        req(1'b1, 1'b0, 32'h0300_0000, 32'h0);
        checks++;
        if (read_valid !== 1'b1 || read_config_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_n1: rv=%b data=%h required 1/DEADBEEF", read_valid, read_config_data);
        end
        @(negedge clk);
        checks++;
        if (read_valid !== 1'b0 || read_config_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_n2: rv=%b data=%h required 0/DEADBEEF (held)", read_valid, read_config_data);
        end
    endtask

    task automatic test_stall_reject();
        stall = 1'b0;
        req(1'b0, 1'b1, 32'h0100_0000, 32'd5);
        checks++;
        if (cfg_regs[63:32] !== 32'h0 || cfg_err !== 1'b1 || write_count !== 16'd1) begin
            errors++;
            $display("FAIL stall_reject: reg1=%h err=%b wc=%h required 0/1/1", cfg_regs[63:32], cfg_err, write_count);
        end
    endtask

    task automatic test_commit();
        do_reset();
        stall = 1'b1;
        req(1'b0, 1'b1, 32'h0F00_0000, 32'd0);
        checks++;
        if (config_done !== 1'b0) begin
            errors++;
            $display("FAIL commit_bit0_clear: done=%b required 0", config_done);
        end
        req(1'b0, 1'b1, 32'h0F00_0000, 32'd1);
        checks++;
        if (config_done !== 1'b1 || write_count !== 16'd2) begin
            errors++;
            $display("FAIL commit_ready: done=%b wc=%h required 1/2", config_done, write_count);
        end
        req(1'b0, 1'b1, 32'h0F00_0000, 32'd3);
        checks++;
        if (config_done !== 1'b1) begin
            errors++;
            $display("FAIL commit_in_ready: done=%b required 1", config_done);
        end
        req(1'b0, 1'b1, 32'h0200_0000, 32'd9);
        checks++;
        if (config_done !== 1'b0 || cfg_regs[95:64] !== 32'd9 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL ready_to_cfging: done=%b reg2=%h err=%b required 0/9/0", config_done, cfg_regs[95:64], cfg_err);
        end
        // Direct UNCFG -> READY.
        do_reset();
        req(1'b0, 1'b1, 32'h0F00_0000, 32'd1);
        checks++;
        if (config_done !== 1'b1) begin
            errors++;
            $display("FAIL uncfg_to_ready: done=%b required 1", config_done);
        end
    endtask

    task automatic test_rw_collision();
        do_reset();
        stall = 1'b1;
        req(1'b1, 1'b1, 32'h0200_0000, 32'd7);
        checks++;
        if (read_valid !== 1'b0 || cfg_regs[95:64] !== 32'd7 || cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL rw_collision: rv=%b reg2=%h err=%b required 0/7/1", read_valid, cfg_regs[95:64], cfg_err);
        end
        do_reset();
        req(1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF);
        checks++;
        if (cfg_regs !== '0 || cfg_err !== 1'b0 || write_count !== 16'd0 || config_done !== 1'b0) begin
            errors++;
            $display("FAIL tile_miss: regs_nz=%0d err=%b wc=%h done=%b required 0/0/0/0",
                     cfg_regs != '0, cfg_err, write_count, config_done);
        end
        req(1'b1, 1'b0, 32'h0000_0001, 32'h0);
        checks++;
        if (read_valid !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL tile_miss_read: rv=%b err=%b required 0/0", read_valid, cfg_err);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        stall = 1'b1;
        req(1'b0, 1'b1, 32'h0300_0000, 32'h1234_5678);
        req(1'b1, 1'b0, 32'h0300_0000, 32'h0);
        checks++;
        if (read_valid !== 1'b1 || read_config_data !== 32'h1234_5678 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_setup: rv=%b data=%h err=%b required 1/12345678/0", read_valid, read_config_data, cfg_err);
        end
        req(1'b0, 1'b1, 32'h1000_0000, 32'hAAAA_AAAA);
        checks++;
        if (cfg_err !== 1'b1 || write_count !== 16'd1 || cfg_regs[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL oor_write: err=%b wc=%h reg0=%h required 1/1/0", cfg_err, write_count, cfg_regs[31:0]);
        end
        req(1'b1, 1'b0, 32'h1000_0000, 32'h0);
        checks++;
        if (read_valid !== 1'b1 || read_config_data !== 32'h0) begin
            errors++;
            $display("FAIL oor_read: rv=%b data=%h required 1/0", read_valid, read_config_data);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        stall = 1'b1;
        req(1'b0, 1'b1, 32'h0500_0000, 32'h55);
        req(1'b0, 1'b1, 32'h0F00_0000, 32'd1);
        req(1'b1, 1'b0, 32'h0500_0000, 32'h0);
        checks++;
        if (config_done !== 1'b1 || read_valid !== 1'b1 || read_config_data !== 32'h55) begin
            errors++;
            $display("FAIL async_pre: done=%b rv=%b data=%h required 1/1/55", config_done, read_valid, read_config_data);
        end
        // Mid-cycle: negedge plus 1, well before the next posedge.
        #1 reset = 1'b1;
        #1;
        checks++;
        if (cfg_regs !== '0 || read_config_data !== 32'h0 || read_valid !== 1'b0 ||
            write_count !== 16'h0 || cfg_err !== 1'b0 || config_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: regs_nz=%0d rdata=%h rv=%b wc=%h err=%b done=%b required all 0",
                     cfg_regs != '0, read_config_data, read_valid, write_count, cfg_err, config_done);
        end
        @(negedge clk);
        reset = 1'b0;
        req(1'b0, 1'b1, 32'h0400_0000, 32'h44);
        checks++;
        if (cfg_regs[159:128] !== 32'h44 || write_count !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_write: reg4=%h wc=%h required 44/1", cfg_regs[159:128], write_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        stall = 1'b1;
        @(negedge clk);
        config_write = 1'b1;
        config_config_addr = 32'h0000_0000;
        config_config_data = 32'h1;
        repeat (65535) @(negedge clk);
        config_write = 1'b0;
        checks++;
        if (write_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL count_full: wc=%h required FFFF", write_count);
        end
        req(1'b0, 1'b1, 32'h0000_0000, 32'h2);
        checks++;
        if (write_count !== 16'hFFFF || cfg_regs[31:0] !== 32'h2) begin
            errors++;
            $display("FAIL count_saturate: wc=%h reg0=%h required FFFF/2", write_count, cfg_regs[31:0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        config_read = 1'b0;
        config_write = 1'b0;
        config_config_addr = '0;
        config_config_data = '0;
        test_reset();
        test_write_read();
        test_stall_reject();
        test_commit();
        test_rw_collision();
        test_out_of_range();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
